dma_write_narrow_to_wide: RTL and testbench

- Downstream of the host DMA slave port, upstream of the M00 memory master.
- Accepts single-beat 32-bit AXI writes and issues them as single-beat 128-bit writes with lane-shifted data and strobe.
- Writes are posted: the DMA B response is returned when the wide write is accepted, not when the memory responds.
- Outstanding wide writes are limited by a credit/ID pool, and the live credit count is exported for the host credit query.

---
 rtl/dma_write_narrow_to_wide_pkg.sv | 21 ++
 rtl/dma_write_narrow_to_wide_id_pool.sv | 62 ++++++
 rtl/dma_write_narrow_to_wide.sv | 197 +++++++++++++++++++
 tb/tb_dma_write_narrow_to_wide.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_write_narrow_to_wide_pkg.sv
// Shared types and constants for the narrow-to-wide posted DMA write bridge.
// Optional response checking is enabled by defining DMA_WIDE_WRITE_ERR_CHECK_EN.
package dma_write_narrow_to_wide_pkg;

    localparam int ID_W_DEF    = 6;
    localparam int CREDITS_DEF = 63;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // 32-bit lane inside a 128-bit beat
    typedef logic [1:0] lane_t;

    typedef logic [ID_W_DEF-1:0] credit_t;

endpackage

// File: rtl/dma_write_narrow_to_wide_id_pool.sv
// Free-ID bitmap with lowest-free allocation and a live free-ID count.
// A free and an allocation in the same cycle never hand out the freed ID.
module id_pool_alloc
    import dma_write_narrow_to_wide_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int CREDITS = CREDITS_DEF
) (
    input  logic            clock,
    input  logic            RESETn,
    input  logic            i_alloc,
    input  logic            i_free_valid,
    input  logic [ID_W-1:0] i_free_id,
    output logic [ID_W-1:0] o_alloc_id,
    output logic            o_any_free,
    output logic            o_free_hit,
    output logic [ID_W-1:0] o_count
);

    logic [CREDITS-1:0] r_busy;
    logic [ID_W-1:0]    r_count;
    logic [CREDITS-1:0] w_free_onehot;
    logic [CREDITS-1:0] w_alloc_onehot;
    logic [ID_W-1:0]    w_low;

    // Scan from the top so the lowest free index wins
    always_comb begin
        w_low = '0;
        for (int i = CREDITS - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_low = ID_W'(i);
        end
    end

    // Responses for IDs that are not outstanding produce no free
    always_comb begin
        w_free_onehot = '0;
        for (int i = 0; i < CREDITS; i++) begin
            w_free_onehot[i] = i_free_valid && (i_free_id == ID_W'(i)) && r_busy[i];
        end
    end

    assign w_alloc_onehot = i_alloc ? ({{(CREDITS-1){1'b0}}, 1'b1} << w_low) : '0;
    assign o_free_hit     = |w_free_onehot;
    assign o_alloc_id     = w_low;
    assign o_any_free     = (r_count != '0);
    assign o_count        = r_count;

    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) begin
            r_busy  <= '0;
            r_count <= ID_W'(CREDITS);
        end else begin
            r_busy <= (r_busy & ~w_free_onehot) | w_alloc_onehot;
            case ({i_alloc, o_free_hit})
                2'b10:   r_count <= r_count - ID_W'(1);
                2'b01:   r_count <= r_count + ID_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dma_write_narrow_to_wide.sv
// Posted bridge: single-beat 32-bit DMA writes become lane-placed 128-bit writes.
// Defining DMA_WIDE_WRITE_ERR_CHECK_EN adds m_bresp and a sticky response error flag.
module dma_write_narrow_to_wide
    import dma_write_narrow_to_wide_pkg::*;
#(
    parameter int ADDR_W   = 49,
    parameter int NARROW_W = 32,
    parameter int WIDE_W   = 128,
    parameter int ID_W     = 6,
    parameter int CREDITS  = 63
) (
    input  logic                  clock,
    input  logic                  RESETn,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [NARROW_W-1:0]   s_wdata,
    input  logic [NARROW_W/8-1:0] s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [ID_W-1:0]       m_awid,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [WIDE_W-1:0]     m_wdata,
    output logic [WIDE_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [ID_W-1:0]       m_bid,
    output logic [ID_W-1:0]       credits_avail,
    output state_t                o_dbg_state
`ifdef DMA_WIDE_WRITE_ERR_CHECK_EN
    ,
    output logic                  err_sticky,
    input  logic [1:0]            m_bresp
`endif
);

    localparam int NSTRB = NARROW_W / 8;
    localparam int WSTRB = WIDE_W / 8;

    // Valid/ready semantics on every channel: a transfer happens on the rising
    // edge where valid and ready are both high; valid never waits on ready.

    state_t r_state, w_next;

    logic                r_run;
    logic                r_aw_full, r_w_full;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic [NARROW_W-1:0] r_w_data;
    logic [NSTRB-1:0]    r_w_strb;
    logic                r_m_awvalid, r_m_wvalid, r_s_bvalid;
    logic [ADDR_W-1:0]   r_m_awaddr;
    logic [ID_W-1:0]     r_m_awid;
    logic [WIDE_W-1:0]   r_m_wdata;
    logic [WSTRB-1:0]    r_m_wstrb;

    logic            w_alloc, w_issue_done, w_aw_done, w_w_done;
    logic            w_any_free, w_free_hit, w_free_valid;
    logic [ID_W-1:0] w_alloc_id, w_count;
    lane_t           w_lane;
    logic [WSTRB-1:0] w_strb_shift;
    logic            w_unused;

    assign w_aw_done    = !r_m_awvalid || m_awready;
    assign w_w_done     = !r_m_wvalid || m_wready;
    assign w_free_valid = m_bvalid && r_run;
    assign w_lane       = r_aw_addr[3:2];
    assign w_strb_shift = {{(WSTRB-NSTRB){1'b0}}, r_w_strb} << (int'(w_lane) * NSTRB);
    assign w_unused     = &{1'b0, s_awaddr[1:0], w_free_hit};

    id_pool_alloc #(
        .ID_W    (ID_W),
        .CREDITS (CREDITS)
    ) u_id_pool (
        .clock        (clock),
        .RESETn       (RESETn),
        .i_alloc      (w_alloc),
        .i_free_valid (w_free_valid),
        .i_free_id    (m_bid),
        .o_alloc_id   (w_alloc_id),
        .o_any_free   (w_any_free),
        .o_free_hit   (w_free_hit),
        .o_count      (w_count)
    );

    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Holding s_bvalid low before a new issue keeps one posted response in flight
    always_comb begin
        w_next       = r_state;
        w_alloc      = 1'b0;
        w_issue_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_aw_full && r_w_full && w_any_free && !r_s_bvalid) begin
                    w_alloc = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (w_aw_done && w_w_done) begin
                    w_issue_done = 1'b1;
                    w_next       = RESP;
                end
            end
            RESP: begin
                if (s_bready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) begin
            r_run       <= 1'b0;
            r_aw_full   <= 1'b0;
            r_w_full    <= 1'b0;
            r_aw_addr   <= '0;
            r_w_data    <= '0;
            r_w_strb    <= '0;
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_s_bvalid  <= 1'b0;
            r_m_awaddr  <= '0;
            r_m_awid    <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_issue_done) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (s_awvalid && s_awready) begin
                    r_aw_full <= 1'b1;
                    r_aw_addr <= s_awaddr;
                end
                if (s_wvalid && s_wready) begin
                    r_w_full <= 1'b1;
                    r_w_data <= s_wdata;
                    r_w_strb <= s_wstrb;
                end
            end
            if (w_alloc) begin
                r_m_awvalid <= 1'b1;
                r_m_wvalid  <= 1'b1;
                r_m_awaddr  <= {r_aw_addr[ADDR_W-1:4], 4'b0000};
                r_m_awid    <= w_alloc_id;
                r_m_wdata   <= {(WIDE_W/NARROW_W){r_w_data}};
                r_m_wstrb   <= w_strb_shift;
            end else begin
                if (m_awready) r_m_awvalid <= 1'b0;
                if (m_wready)  r_m_wvalid  <= 1'b0;
            end
            if (w_issue_done)  r_s_bvalid <= 1'b1;
            else if (s_bready) r_s_bvalid <= 1'b0;
        end
    end

`ifdef DMA_WIDE_WRITE_ERR_CHECK_EN
    logic r_err;
    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) begin
            r_err <= 1'b0;
        end else if (w_free_valid && (!w_free_hit || m_bresp != AXI_RESP_OKAY)) begin
            r_err <= 1'b1;
        end
    end
    assign err_sticky = r_err;
`endif

    assign s_awready     = r_run && !r_aw_full;
    assign s_wready      = r_run && !r_w_full;
    assign s_bvalid      = r_s_bvalid;
    assign s_bresp       = AXI_RESP_OKAY;
    assign m_awvalid     = r_m_awvalid;
    assign m_awaddr      = r_m_awaddr;
    assign m_awid        = r_m_awid;
    assign m_wvalid      = r_m_wvalid;
    assign m_wdata       = r_m_wdata;
    assign m_wstrb       = r_m_wstrb;
    assign m_wlast       = 1'b1;
    assign m_bready      = r_run;
    assign credits_avail = w_count;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dma_write_narrow_to_wide.sv
// Randomized bench for dma_write_narrow_to_wide against a queue/set reference model.
// Builds with or without DMA_WIDE_WRITE_ERR_CHECK_EN.
`timescale 1ns/1ps
module tb_dma_write_narrow_to_wide;
  import dma_write_narrow_to_wide_pkg::*;

  localparam int ADDR_W   = 49;
  localparam int NARROW_W = 32;
  localparam int WIDE_W   = 128;
  localparam int ID_W     = 6;
  localparam int CREDITS  = 63;
  localparam int EXP_W    = ADDR_W + WIDE_W + 16;

  logic                clock = 1'b0;
  logic                RESETn = 1'b0;
  logic                s_awvalid = 1'b0;
  logic                s_awready;
  logic [ADDR_W-1:0]   s_awaddr = '0;
  logic                s_wvalid = 1'b0;
  logic                s_wready;
  logic [NARROW_W-1:0] s_wdata = '0;
  logic [3:0]          s_wstrb = '0;
  logic                s_bvalid;
  logic                s_bready = 1'b0;
  logic [1:0]          s_bresp;
  logic                m_awvalid;
  logic                m_awready = 1'b0;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [ID_W-1:0]     m_awid;
  logic                m_wvalid;
  logic                m_wready = 1'b0;
  logic [WIDE_W-1:0]   m_wdata;
  logic [15:0]         m_wstrb;
  logic                m_wlast;
  logic                m_bvalid = 1'b0;
  logic                m_bready;
  logic [ID_W-1:0]     m_bid = '0;
  logic [ID_W-1:0]     credits_avail;
  state_t              o_dbg_state;
`ifdef DMA_WIDE_WRITE_ERR_CHECK_EN
  logic                err_sticky;
  logic [1:0]          m_bresp = 2'b00;
`endif

  dma_write_narrow_to_wide dut (
    .clock(clock), .RESETn(RESETn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
    .credits_avail(credits_avail), .o_dbg_state(o_dbg_state)
`ifdef DMA_WIDE_WRITE_ERR_CHECK_EN
    , .err_sticky(err_sticky), .m_bresp(m_bresp)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- knobs set by the sequencer ----------------
  int req_cnt = 0;
  int force_cnt = 0;
  int force_id = 0;
  int b_pct = 0;
  int bogus_pct = 0;
  int ready_pct = 100;
  int valid_pct = 100;
  bit use_dir = 1'b0;
  logic [ADDR_W-1:0]   dir_addr = '0;
  logic [NARROW_W-1:0] dir_data = '0;
  logic [3:0]          dir_strb = '0;

  // ---------------- reference model state ----------------
  logic [EXP_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] aw_pend[$];
  logic [35:0]       w_pend[$];
  bit   model_busy[CREDITS];
  bit   pend_free = 1'b0;
  int   pend_id = 0;
  bit   issue_seen = 1'b0;
  bit   aw_hs = 1'b0;
  bit   w_hs = 1'b0;
  int   issued = 0;
  int   bhs = 0;
  int   last_id = -1;
  int   gen_done = 0;
  int   force_done = 0;
  int   exp_id;
  int   pick;
  int   st;
  int   g_lane;
  logic [ADDR_W-1:0]   g_addr;
  logic [NARROW_W-1:0] g_data;
  logic [3:0]          g_strb;
  logic [EXP_W-1:0]    g_exp;
  logic [35:0]         g_w;

  function automatic int lowest_free();
    for (int i = 0; i < CREDITS; i++) if (!model_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < CREDITS; i++) if (model_busy[i]) n++;
    return n;
  endfunction

  // ---------------- driver + monitor (one process, negedge) ----------------
  always @(negedge clock) begin
    if (!RESETn) begin
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0;
      for (int i = 0; i < CREDITS; i++) model_busy[i] = 1'b0;
      pend_free = 1'b0; issue_seen = 1'b0; aw_hs = 1'b0; w_hs = 1'b0;
      exp_q.delete(); aw_pend.delete(); w_pend.delete();
      gen_done = req_cnt; force_done = force_cnt;
    end else begin
      // a new wide write became visible in this cycle
      if ((m_awvalid || m_wvalid) && !issue_seen) begin
        issue_seen = 1'b1;
        check_val("issue_valids_together", {m_awvalid, m_wvalid}, 2'b11);
        exp_id = lowest_free();
        check_val("m_awid", m_awid, exp_id);
        if (exp_id >= 0) model_busy[exp_id] = 1'b1;
        last_id = int'(m_awid);
        if (exp_q.size() == 0) begin
          check_val("issue_without_request", exp_q.size(), 1);
        end else begin
          g_exp = exp_q.pop_front();
          check_val("m_awaddr", m_awaddr, g_exp[EXP_W-1 -: ADDR_W]);
          check_val("m_wdata", m_wdata, g_exp[16 +: WIDE_W]);
          check_val("m_wstrb", m_wstrb, g_exp[15:0]);
          check_val("m_wlast", m_wlast, 1'b1);
        end
        issued++;
      end
      if (!m_awvalid && !m_wvalid) issue_seen = 1'b0;

      // free driven last cycle took effect at the edge just passed
      if (pend_free) model_busy[pend_id] = 1'b0;
      pend_free = 1'b0;
      check_val("credits_avail", credits_avail, CREDITS - busy_count());

      // posted response towards the DMA
      s_bready = ($urandom_range(0, 99) < ready_pct);
      if (s_bvalid) check_val("s_bresp", s_bresp, AXI_RESP_OKAY);
      if (s_bvalid && s_bready) bhs++;

      // memory side
      m_awready = ($urandom_range(0, 99) < ready_pct);
      m_wready  = ($urandom_range(0, 99) < ready_pct);
      m_bvalid  = 1'b0;
      if (force_done != force_cnt) begin
        force_done = force_cnt;
        m_bvalid = 1'b1;
        m_bid = ID_W'(force_id);
      end else if ($urandom_range(0, 99) < b_pct) begin
        st = $urandom_range(0, CREDITS - 1);
        pick = -1;
        for (int k = 0; k < CREDITS; k++)
          if (pick < 0 && model_busy[(st + k) % CREDITS]) pick = (st + k) % CREDITS;
        if (pick >= 0) begin m_bvalid = 1'b1; m_bid = ID_W'(pick); end
      end else if ($urandom_range(0, 99) < bogus_pct) begin
        pick = $urandom_range(0, 63);
        if (pick >= CREDITS || !model_busy[pick]) begin m_bvalid = 1'b1; m_bid = ID_W'(pick); end
      end
      if (m_bvalid && int'(m_bid) < CREDITS && model_busy[m_bid]) begin
        pend_free = 1'b1;
        pend_id = int'(m_bid);
      end

      // generate requested writes and their expected wide form
      if (gen_done != req_cnt && aw_pend.size() < 2 && w_pend.size() < 2) begin
        if (use_dir) begin
          g_addr = dir_addr; g_data = dir_data; g_strb = dir_strb;
        end else begin
          g_addr = {17'($urandom), 32'($urandom)};
          g_data = $urandom;
          g_strb = 4'($urandom_range(0, 15));
        end
        aw_pend.push_back(g_addr);
        w_pend.push_back({g_data, g_strb});
        g_lane = int'(g_addr[3:2]);
        exp_q.push_back({g_addr & ~49'hF, {4{g_data}}, 16'(g_strb) * (16'd1 << (4 * g_lane))});
        gen_done++;
      end

      // DMA AW and W driven independently
      if (aw_hs) begin s_awvalid = 1'b0; aw_hs = 1'b0; end
      if (!s_awvalid && aw_pend.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        s_awvalid = 1'b1;
        s_awaddr = aw_pend.pop_front();
      end
      if (s_awvalid && s_awready) aw_hs = 1'b1;
      if (w_hs) begin s_wvalid = 1'b0; w_hs = 1'b0; end
      if (!s_wvalid && w_pend.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        s_wvalid = 1'b1;
        g_w = w_pend.pop_front();
        s_wdata = g_w[35:4];
        s_wstrb = g_w[3:0];
      end
      if (s_wvalid && s_wready) w_hs = 1'b1;
    end
  end

  // ---------------- sequencer helpers ----------------
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wait_issued(input int target, input int budget, input string tag);
    int n = 0;
    while (issued < target && n < budget) begin step(); n++; end
    check_val(tag, issued, target);
  endtask

  task automatic wait_credits(input int target, input int budget, input string tag);
    int n = 0;
    while (int'(credits_avail) != target && n < budget) begin step(); n++; end
    check_val(tag, credits_avail, target);
  endtask

  task automatic wait_bhs(input int target, input int budget, input string tag);
    int n = 0;
    while (bhs < target && n < budget) begin step(); n++; end
    check_val(tag, bhs, target);
  endtask

  // ---------------- sequence ----------------
  int base;
  int bbase;

  initial begin
    RESETn = 1'b0;
    repeat (3) step();
    check_val("rst_credits", credits_avail, CREDITS);
    check_val("rst_valids", {m_awvalid, m_wvalid, s_bvalid}, 3'b000);
    check_val("rst_readies", {s_awready, s_wready, m_bready}, 3'b000);
    RESETn = 1'b1;
    #1;
    check_val("bready_before_edge", m_bready, 1'b0);
    step();
    check_val("bready_after_edge", m_bready, 1'b1);
    check_val("aw_w_ready_after_reset", {s_awready, s_wready}, 2'b11);

    // single directed write at lane 1
    dir_addr = 49'hDE04; dir_data = 32'hDEADBEEF; dir_strb = 4'hF; use_dir = 1'b1;
    req_cnt = req_cnt + 1;
    wait_issued(1, 200, "dir_issue");
    use_dir = 1'b0;
    check_val("dir_awaddr", m_awaddr, 49'hDE00);
    check_val("dir_wstrb", m_wstrb, 16'h00F0);
    check_val("dir_wdata", m_wdata, {4{32'hDEADBEEF}});
    check_val("dir_id", last_id, 0);
    wait_bhs(1, 200, "dir_bresp");
    repeat (3) step();
    check_val("dir_credits_held", credits_avail, CREDITS - 1);
    b_pct = 100;
    wait_credits(CREDITS, 200, "dir_credits_back");

    // 60 outstanding, no responses
    b_pct = 0; base = issued;
    req_cnt = req_cnt + 60;
    wait_issued(base + 60, 2000, "burst60_issue");
    check_val("burst60_credits", credits_avail, 3);
    check_val("burst60_last_id", last_id, 59);
    b_pct = 100;
    wait_credits(CREDITS, 500, "burst60_drain");

    // pool exhaustion: 64th write must wait for a freed ID
    b_pct = 0; base = issued;
    req_cnt = req_cnt + 64;
    wait_issued(base + 63, 3000, "full_issue");
    repeat (20) step();
    check_val("full_credits", credits_avail, 0);
    check_val("full_stalled", issued, base + 63);
    check_val("full_backpressure", {s_awready, s_wready}, 2'b00);
    force_id = 17; force_cnt = force_cnt + 1;
    wait_issued(base + 64, 200, "full_resume");
    check_val("full_reuse_id", last_id, 17);
    b_pct = 100;
    wait_credits(CREDITS, 500, "full_drain");

`ifdef DMA_WIDE_WRITE_ERR_CHECK_EN
    b_pct = 0;
    repeat (3) step();
    check_val("err_clear", err_sticky, 1'b0);
    force_id = 50; force_cnt = force_cnt + 1;
    repeat (3) step();
    check_val("err_set", err_sticky, 1'b1);
    check_val("err_credits", credits_avail, CREDITS);
`endif

    // randomized traffic with overlapping alloc/free and stray responses
    base = issued;
    b_pct = 40; bogus_pct = 10; ready_pct = 70; valid_pct = 70;
    req_cnt = req_cnt + 300;
    wait_issued(base + 300, 20000, "rand_issue");
    ready_pct = 100; valid_pct = 100; bogus_pct = 0; b_pct = 100;
    wait_credits(CREDITS, 500, "rand_drain");
    wait_bhs(issued, 200, "rand_bresp_count");
    check_val("rand_queue_empty", exp_q.size(), 0);

    // reset in the middle of traffic
    b_pct = 0; base = issued;
    req_cnt = req_cnt + 5;
    wait_issued(base + 3, 500, "midrst_issue");
    RESETn = 1'b0;
    #1;
    check_val("midrst_credits", credits_avail, CREDITS);
    check_val("midrst_valids", {m_awvalid, m_wvalid, s_bvalid, m_bready}, 4'b0000);
    repeat (2) step();
    RESETn = 1'b1;
    step();
    base = issued;
    req_cnt = req_cnt + 1;
    wait_issued(base + 1, 200, "postrst_issue");
    check_val("postrst_id", last_id, 0);
    check_val("postrst_credits", credits_avail, CREDITS - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
